// File: rtl/issue_ctrl.sv
// In-order dual-issue scheduler with a register scoreboard and a serializing drain FSM.
// Optional performance counters are compiled in when ISSUE_PERF_EN is defined.
module issue_ctrl #(
  parameter int NREG         = 32,
  parameter int SB_CLR_PORTS = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      a_valid,
  input  logic [1:0]                a_class,
  input  logic                      a_is_br,
  input  logic [4:0]                a_dest,
  input  logic [4:0]                a_r1,
  input  logic [4:0]                a_r2,
  input  logic                      a_src2_is_imm,
  input  logic                      b_valid,
  input  logic [1:0]                b_class,
  input  logic                      b_is_br,
  input  logic [4:0]                b_dest,
  input  logic [4:0]                b_r1,
  input  logic [4:0]                b_r2,
  input  logic                      b_src2_is_imm,
  input  logic                      exe_ready,
  input  logic                      pipe_empty,
  input  logic [SB_CLR_PORTS-1:0]   wb_valid,
  input  logic [5*SB_CLR_PORTS-1:0] wb_dest,
  output logic [1:0]                o_size,
  output logic                      serial_busy,
  output logic                      sb_empty
`ifdef ISSUE_PERF_EN
  ,
  output logic [31:0]               perf_dual,
  output logic [31:0]               perf_single,
  output logic [31:0]               perf_stall_dep,
  output logic [31:0]               perf_stall_serial
`endif
);

  localparam logic [1:0] CLS_ALU    = 2'd0;
  localparam logic [1:0] CLS_LONG   = 2'd1;
  localparam logic [1:0] CLS_MEM    = 2'd2;
  localparam logic [1:0] CLS_SERIAL = 2'd3;

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_ISSUE  = 2'd2,
    ST_WAIT   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [NREG-1:0]   sb_q, sb_d;
  logic [NREG-1:0]   set_mask, clr_mask;
  logic [NREG-1:0]   clr_port [SB_CLR_PORTS];
  logic              issue_a, issue_b;
  logic              ok_a, ok_b;
  logic              a_serial;
  logic              dep_stall;

  function automatic logic is_busy(input logic [NREG-1:0] sb, input logic [4:0] r);
    return (r != 5'd0) && sb[r];
  endfunction

  function automatic logic sets_sb(input logic [1:0] cls, input logic [4:0] d);
    return ((cls == CLS_LONG) || (cls == CLS_MEM)) && (d != 5'd0);
  endfunction

  assign a_serial = a_valid && (a_class == CLS_SERIAL);

  assign ok_a = a_valid && exe_ready && !is_busy(sb_q, a_r1) &&
                (a_src2_is_imm || !is_busy(sb_q, a_r2));

  // Pairing rules for slot B; A's own checks are folded in by requiring issue_a.
  assign ok_b = b_valid && (b_class != CLS_SERIAL) && !a_is_br &&
                !((a_class == CLS_MEM) && (b_class == CLS_MEM)) &&
                !is_busy(sb_q, b_r1) && (b_src2_is_imm || !is_busy(sb_q, b_r2)) &&
                !((a_dest != 5'd0) &&
                  ((b_r1 == a_dest) || (!b_src2_is_imm && (b_r2 == a_dest)))) &&
                (b_dest != a_dest);

  always_comb begin
    state_d = state_q;
    issue_a = 1'b0;
    issue_b = 1'b0;
    unique case (state_q)
      ST_NORMAL: begin
        if (a_serial) begin
          state_d = ST_DRAIN;
        end else if (ok_a) begin
          issue_a = 1'b1;
          issue_b = ok_b;
        end
      end
      ST_DRAIN: begin
        if (!a_valid) begin
          state_d = ST_NORMAL;
        end else if (pipe_empty && sb_empty) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (a_valid && exe_ready) begin
          issue_a = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (pipe_empty) begin
          state_d = ST_NORMAL;
        end
      end
      default: state_d = ST_NORMAL;
    endcase
    if (flush) begin
      issue_a = 1'b0;
      issue_b = 1'b0;
      state_d = ST_NORMAL;
    end
  end

  // Reset gates the pop count combinationally so the buffer never pops while reset is held.
  assign o_size      = reset ? 2'd0 : (2'(issue_a) + 2'(issue_b));
  assign serial_busy = (state_q != ST_NORMAL);
  assign sb_empty    = ~|sb_q;

  generate
    for (genvar gi = 0; gi < SB_CLR_PORTS; gi++) begin : g_clr
      assign clr_port[gi] = wb_valid[gi] ?
                            ({{(NREG-1){1'b0}}, 1'b1} << wb_dest[5*gi +: 5]) : '0;
    end
  endgenerate

  always_comb begin
    clr_mask = '0;
    for (int i = 0; i < SB_CLR_PORTS; i++) begin
      clr_mask = clr_mask | clr_port[i];
    end
  end

  always_comb begin
    set_mask = '0;
    if (issue_a && sets_sb(a_class, a_dest)) set_mask[a_dest] = 1'b1;
    if (issue_b && sets_sb(b_class, b_dest)) set_mask[b_dest] = 1'b1;
  end

  // Set is applied after clear so a same-cycle set of a retiring register wins.
  always_comb begin
    sb_d    = (sb_q & ~clr_mask) | set_mask;
    sb_d[0] = 1'b0;
    if (flush) sb_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_NORMAL;
      sb_q    <= '0;
    end else begin
      state_q <= state_d;
      sb_q    <= sb_d;
    end
  end

  assign dep_stall = (state_q == ST_NORMAL) && a_valid && (a_class != CLS_SERIAL) &&
                     exe_ready && !ok_a && !flush;

`ifdef ISSUE_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_dual         <= '0;
      perf_single       <= '0;
      perf_stall_dep    <= '0;
      perf_stall_serial <= '0;
    end else begin
      if (o_size == 2'd2) perf_dual <= perf_dual + 32'd1;
      if (o_size == 2'd1) perf_single <= perf_single + 32'd1;
      if (dep_stall) perf_stall_dep <= perf_stall_dep + 32'd1;
      if ((state_q == ST_DRAIN) || (state_q == ST_WAIT))
        perf_stall_serial <= perf_stall_serial + 32'd1;
    end
  end
`else
  logic unused_ok;
  assign unused_ok = ^{dep_stall, b_is_br, CLS_ALU};
`endif

endmodule

// File: tb/tb_issue_ctrl.sv
// Bench for issue_ctrl: directed scenarios, then random traffic against a buffer/pipeline model.
module tb_issue_ctrl;

  logic        clk, reset, flush;
  logic        a_valid, a_is_br, a_src2_is_imm;
  logic [1:0]  a_class;
  logic [4:0]  a_dest, a_r1, a_r2;
  logic        b_valid, b_is_br, b_src2_is_imm;
  logic [1:0]  b_class;
  logic [4:0]  b_dest, b_r1, b_r2;
  logic        exe_ready, pipe_empty;
  logic [1:0]  wb_valid;
  logic [9:0]  wb_dest;
  logic [1:0]  o_size;
  logic        serial_busy, sb_empty;

  localparam logic [1:0] ALU = 2'd0, LNG = 2'd1, MEM = 2'd2, SER = 2'd3;

  int n_checks = 0;
  int n_fail   = 0;

  issue_ctrl dut (
    .clk(clk), .reset(reset), .flush(flush),
    .a_valid(a_valid), .a_class(a_class), .a_is_br(a_is_br), .a_dest(a_dest),
    .a_r1(a_r1), .a_r2(a_r2), .a_src2_is_imm(a_src2_is_imm),
    .b_valid(b_valid), .b_class(b_class), .b_is_br(b_is_br), .b_dest(b_dest),
    .b_r1(b_r1), .b_r2(b_r2), .b_src2_is_imm(b_src2_is_imm),
    .exe_ready(exe_ready), .pipe_empty(pipe_empty),
    .wb_valid(wb_valid), .wb_dest(wb_dest),
    .o_size(o_size), .serial_busy(serial_busy), .sb_empty(sb_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic set_a(input logic v, input logic [1:0] c, input logic [4:0] d,
                       input logic [4:0] s1, input logic [4:0] s2, input logic im, input logic br);
    a_valid = v; a_class = c; a_dest = d; a_r1 = s1; a_r2 = s2; a_src2_is_imm = im; a_is_br = br;
  endtask

  task automatic set_b(input logic v, input logic [1:0] c, input logic [4:0] d,
                       input logic [4:0] s1, input logic [4:0] s2, input logic im, input logic br);
    b_valid = v; b_class = c; b_dest = d; b_r1 = s1; b_r2 = s2; b_src2_is_imm = im; b_is_br = br;
  endtask

  task automatic idle();
    set_a(0, ALU, 0, 0, 0, 0, 0);
    set_b(0, ALU, 0, 0, 0, 0, 0);
    flush = 0; exe_ready = 1; pipe_empty = 1; wb_valid = 0; wb_dest = 0;
  endtask

  // ---------------- reference model for the random phase ----------------
  typedef struct packed {
    logic [1:0] cls;
    logic       br;
    logic [4:0] dest, r1, r2;
    logic       imm;
  } instr_t;

  typedef struct {
    logic [4:0] dest;
    bit         wb;
    int         cnt;
    bit         done;
  } fl_t;

  instr_t     buf_q[$];
  fl_t        infl[$];
  int         mphase;     // 0 normal, 1 draining, 2 waiting to issue, 3 waiting for pipe
  bit [31:0]  msb;

  function automatic bit mbusy(input logic [4:0] r);
    return (r != 0) && msb[r];
  endfunction

  function automatic instr_t rand_instr();
    instr_t t;
    int r = $urandom_range(0, 19);
    t.cls  = (r < 9) ? ALU : (r < 13) ? LNG : (r < 18) ? MEM : SER;
    t.br   = ($urandom_range(0, 5) == 0);
    t.dest = 5'($urandom_range(0, 7));
    t.r1   = 5'($urandom_range(0, 7));
    t.r2   = 5'($urandom_range(0, 7));
    t.imm  = 1'($urandom_range(0, 1));
    return t;
  endfunction

  task automatic rand_cycle();
    instr_t A, B, g;
    bit av, bv;
    int es, nph, nport;
    bit [31:0] nsb;
    fl_t e;
    fl_t nq[$];

    @(negedge clk);
    flush      = ($urandom_range(0, 59) == 0);
    exe_ready  = ($urandom_range(0, 3) != 0);
    pipe_empty = (infl.size() == 0);
    wb_valid = 0; wb_dest = 0; nport = 0;
    foreach (infl[i]) begin
      if (infl[i].cnt == 0) begin
        if (!infl[i].wb) infl[i].done = 1;
        else if (nport < 2) begin
          wb_valid[nport] = 1'b1;
          wb_dest[5*nport +: 5] = infl[i].dest;
          infl[i].done = 1;
          nport++;
        end
      end
    end
    av = (buf_q.size() > 0);
    bv = (buf_q.size() > 1);
    A = av ? buf_q[0] : rand_instr();
    B = bv ? buf_q[1] : rand_instr();
    set_a(av, A.cls, A.dest, A.r1, A.r2, A.imm, A.br);
    set_b(bv, B.cls, B.dest, B.r1, B.r2, B.imm, B.br);
    #1;

    es = 0; nph = mphase; nsb = msb;
    case (mphase)
      0: begin
        if (av && A.cls == SER) nph = 1;
        else if (av && exe_ready && !mbusy(A.r1) && (A.imm || !mbusy(A.r2))) begin
          es = 1;
          if (bv && B.cls != SER && !A.br && !(A.cls == MEM && B.cls == MEM) &&
              !mbusy(B.r1) && (B.imm || !mbusy(B.r2)) &&
              !(A.dest != 0 && (B.r1 == A.dest || (!B.imm && B.r2 == A.dest))) &&
              B.dest != A.dest)
            es = 2;
        end
      end
      1: begin
        if (!av) nph = 0;
        else if (pipe_empty && msb == 0) nph = 2;
      end
      2: if (exe_ready) begin es = 1; nph = 3; end
      default: if (pipe_empty) nph = 0;
    endcase
    if (flush) begin es = 0; nph = 0; end

    for (int p = 0; p < 2; p++)
      if (wb_valid[p]) nsb[wb_dest[5*p +: 5]] = 1'b0;
    for (int k = 0; k < es; k++) begin
      g = (k == 0) ? A : B;
      if ((g.cls == LNG || g.cls == MEM) && g.dest != 0) nsb[g.dest] = 1'b1;
    end
    if (flush) nsb = 0;

    chk("rnd_o_size", 32'(o_size), 32'(es));
    chk("rnd_serial_busy", 32'(serial_busy), 32'(mphase != 0));
    chk("rnd_sb_empty", 32'(sb_empty), 32'(msb == 0));

    foreach (infl[i]) begin
      if (!infl[i].done) begin
        e = infl[i];
        if (e.cnt > 0) e.cnt--;
        nq.push_back(e);
      end
    end
    infl = nq;
    for (int k = 0; k < es; k++) begin
      g = buf_q.pop_front();
      e.dest = g.dest; e.done = 0;
      e.wb   = (g.cls == LNG || g.cls == MEM) && g.dest != 0;
      e.cnt  = (g.cls == LNG) ? $urandom_range(1, 6) :
               (g.cls == MEM) ? $urandom_range(1, 3) : $urandom_range(0, 2);
      infl.push_back(e);
    end
    if (flush) begin
      buf_q.delete();
      infl.delete();
    end
    mphase = nph;
    msb    = nsb;
    for (int k = $urandom_range(0, 2); k > 0 && buf_q.size() < 6; k--)
      buf_q.push_back(rand_instr());
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1;
    idle();
    @(negedge clk);
    set_a(1, ALU, 3, 1, 0, 1, 0);
    #1;
    chk("rst_o_size", 32'(o_size), 0);
    chk("rst_serial_busy", 32'(serial_busy), 0);
    chk("rst_sb_empty", 32'(sb_empty), 1);
    @(negedge clk);
    reset = 0;
    idle();

    // independent pair
    set_a(1, ALU, 3, 1, 0, 1, 0); set_b(1, ALU, 4, 2, 0, 1, 0);
    #1 chk("pair_indep", 32'(o_size), 2);
    @(negedge clk);
    // RAW pair, then B at the head
    set_a(1, ALU, 5, 1, 0, 1, 0); set_b(1, ALU, 6, 5, 0, 1, 0);
    #1 chk("pair_raw", 32'(o_size), 1);
    @(negedge clk);
    set_a(1, ALU, 6, 5, 0, 1, 0); set_b(0, ALU, 0, 0, 0, 0, 0);
    #1 chk("raw_next", 32'(o_size), 1);
    @(negedge clk);
    // load then use
    set_a(1, MEM, 7, 1, 0, 1, 0);
    #1 chk("load_issue", 32'(o_size), 1);
    @(negedge clk);
    set_a(1, ALU, 8, 7, 0, 1, 0);
    #1 chk("load_use_stall", 32'(o_size), 0);
    chk("load_sb_busy", 32'(sb_empty), 0);
    @(negedge clk);
    wb_valid = 2'b01; wb_dest = 10'd7;
    #1 chk("load_use_wb_cycle", 32'(o_size), 0);
    @(negedge clk);
    wb_valid = 0; wb_dest = 0;
    #1 chk("load_use_go", 32'(o_size), 1);
    chk("load_sb_clear", 32'(sb_empty), 1);
    @(negedge clk);

    // serial instruction through the drain sequence
    set_a(1, SER, 0, 0, 0, 1, 0); pipe_empty = 0;
    #1 chk("ser_normal_size", 32'(o_size), 0);
    chk("ser_normal_busy", 32'(serial_busy), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 chk("ser_drain_size", 32'(o_size), 0);
      chk("ser_drain_busy", 32'(serial_busy), 1);
    end
    @(negedge clk);
    pipe_empty = 1;
    #1 chk("ser_drain_exit", 32'(o_size), 0);
    @(negedge clk);
    #1 chk("ser_issue", 32'(o_size), 1);
    @(negedge clk);
    set_a(0, ALU, 0, 0, 0, 0, 0); pipe_empty = 0;
    #1 chk("ser_wait_size", 32'(o_size), 0);
    chk("ser_wait_busy", 32'(serial_busy), 1);
    @(negedge clk);
    pipe_empty = 1;
    #1 chk("ser_wait_busy2", 32'(serial_busy), 1);
    @(negedge clk);
    #1 chk("ser_done", 32'(serial_busy), 0);
    @(negedge clk);

    // same-cycle set and clear of one register
    set_a(1, LNG, 9, 1, 0, 1, 0); wb_valid = 2'b01; wb_dest = 10'd9;
    #1 chk("setclr_issue", 32'(o_size), 1);
    @(negedge clk);
    wb_valid = 0; wb_dest = 0; set_a(1, ALU, 10, 9, 0, 1, 0);
    #1 chk("setclr_busy", 32'(o_size), 0);
    chk("setclr_sb", 32'(sb_empty), 0);
    @(negedge clk);
    set_a(0, ALU, 0, 0, 0, 0, 0); wb_valid = 2'b10; wb_dest = {5'd9, 5'd0};
    @(negedge clk);
    wb_valid = 0; wb_dest = 0;
    #1 chk("setclr_port1_clear", 32'(sb_empty), 1);

    // pairing blockers
    set_a(1, MEM, 0, 1, 0, 1, 0); set_b(1, MEM, 11, 2, 0, 1, 0);
    #1 chk("mem_mem", 32'(o_size), 1);
    @(negedge clk);
    set_a(1, ALU, 0, 1, 0, 1, 1); set_b(1, ALU, 12, 2, 0, 1, 0);
    #1 chk("branch_a", 32'(o_size), 1);
    @(negedge clk);
    set_a(1, ALU, 13, 1, 0, 1, 0); set_b(1, ALU, 13, 2, 0, 1, 0);
    #1 chk("waw", 32'(o_size), 1);
    @(negedge clk);
    set_a(1, ALU, 14, 1, 0, 1, 0); set_b(1, ALU, 15, 1, 14, 1, 0);
    #1 chk("imm_bypass", 32'(o_size), 2);
    @(negedge clk);
    set_a(1, ALU, 14, 1, 0, 1, 0); set_b(1, ALU, 15, 1, 14, 0, 0);
    #1 chk("r2_raw", 32'(o_size), 1);
    @(negedge clk);
    set_a(1, ALU, 16, 1, 0, 1, 0); set_b(1, SER, 0, 0, 0, 1, 0);
    #1 chk("b_serial", 32'(o_size), 1);
    @(negedge clk);
    exe_ready = 0; set_b(0, ALU, 0, 0, 0, 0, 0);
    #1 chk("not_ready", 32'(o_size), 0);
    @(negedge clk);
    exe_ready = 1; set_a(1, ALU, 0, 1, 0, 1, 0); set_b(1, ALU, 17, 0, 0, 0, 0);
    #1 chk("r0_no_hazard", 32'(o_size), 2);
    @(negedge clk);
    set_a(1, LNG, 0, 1, 0, 1, 0); set_b(0, ALU, 0, 0, 0, 0, 0);
    #1 chk("long_r0", 32'(o_size), 1);
    @(negedge clk);
    set_a(0, ALU, 0, 0, 0, 0, 0);
    #1 chk("r0_never_busy", 32'(sb_empty), 1);
    @(negedge clk);

    // a_valid dropping in DRAIN
    set_a(1, SER, 0, 0, 0, 1, 0); pipe_empty = 0;
    @(negedge clk);
    set_a(0, ALU, 0, 0, 0, 0, 0);
    #1 chk("drop_in_drain", 32'(serial_busy), 1);
    @(negedge clk);
    #1 chk("drop_back_normal", 32'(serial_busy), 0);
    pipe_empty = 1;
    @(negedge clk);

    // flush behaviour
    set_a(1, LNG, 18, 1, 0, 1, 0);
    @(negedge clk);
    set_a(0, ALU, 0, 0, 0, 0, 0); flush = 1;
    #1 chk("flush_sb_before", 32'(sb_empty), 0);
    @(negedge clk);
    flush = 0;
    #1 chk("flush_sb_cleared", 32'(sb_empty), 1);
    set_a(1, ALU, 3, 1, 0, 1, 0); flush = 1;
    #1 chk("flush_size", 32'(o_size), 0);
    @(negedge clk);
    flush = 0; set_a(1, SER, 0, 0, 0, 1, 0); pipe_empty = 0;
    @(negedge clk);
    flush = 1;
    #1 chk("flush_in_drain_pre", 32'(serial_busy), 1);
    @(negedge clk);
    flush = 0; set_a(0, ALU, 0, 0, 0, 0, 0); pipe_empty = 1;
    #1 chk("flush_in_drain", 32'(serial_busy), 0);
    @(negedge clk);

    // asynchronous reset in DRAIN with a busy scoreboard
    set_a(1, LNG, 20, 1, 0, 1, 0);
    @(negedge clk);
    set_a(1, SER, 0, 0, 0, 1, 0); pipe_empty = 0;
    @(negedge clk);
    #1 chk("arst_pre_busy", 32'(serial_busy), 1);
    chk("arst_pre_sb", 32'(sb_empty), 0);
    #1;
    reset = 1; set_a(1, ALU, 3, 1, 0, 1, 0);
    #1 chk("arst_o_size", 32'(o_size), 0);
    chk("arst_serial_busy", 32'(serial_busy), 0);
    chk("arst_sb_empty", 32'(sb_empty), 1);
    @(negedge clk);
    reset = 0;
    idle();

    // randomized traffic
    mphase = 0; msb = 0;
    buf_q.delete(); infl.delete();
    for (int c = 0; c < 3000; c++) rand_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/issue_ctrl.md
Name: issue_ctrl

Overview:
- In-order dual-issue scheduler between the instruction buffer and the execute stage.
- Each cycle it inspects the two buffer head entries and drives the buffer's pop count (o_size = 0/1/2), so it controls how many entries leave the buffer.
- Tracks in-flight long-latency register writes with a 32-entry scoreboard.
- Serializes CSR, barrier and exception-carrying instructions through a drain state machine.

Parameters:
- NREG, 32, architectural register count (scoreboard width); r0 is never busy.
- SB_CLR_PORTS, 2, number of writeback ports that clear scoreboard bits.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous pipeline flush from commit
- a_valid  in  1  buffer head entry valid
- a_class  in  2  0=ALU, 1=LONG (mul/div), 2=MEM, 3=SERIAL (CSR/barrier/ertn/have_excp)
- a_is_br  in  1  head entry is a branch
- a_dest  in  5  head destination register
- a_r1  in  5  head source register 1
- a_r2  in  5  head source register 2
- a_src2_is_imm  in  1  head src2 comes from the immediate, r2 ignored
- b_valid, b_class, b_is_br, b_dest, b_r1, b_r2, b_src2_is_imm  in  same widths  second buffer entry
- exe_ready  in  1  execute stage accepts instructions this cycle
- pipe_empty  in  1  all downstream stages hold no valid instruction
- wb_valid  in  SB_CLR_PORTS  writeback port valid
- wb_dest  in  5*SB_CLR_PORTS  writeback destination, port i at bits [5i+4:5i]
- o_size  out  2  entries to pop and issue this cycle
- serial_busy  out  1  state machine is not in NORMAL
- sb_empty  out  1  no scoreboard bit set

Behaviour:
- Reset (async): state=NORMAL, scoreboard=0. While reset is high, o_size=0, serial_busy=0, sb_empty=1.
- flush (sync): state<=NORMAL, scoreboard<=0. o_size=0 in the flush cycle.
- o_size is combinational from current state, scoreboard and inputs; zero latency to the buffer.
- busy(r) = scoreboard[r] and r != 0.
- ok_a = a_valid & exe_ready & !busy(a_r1) & (a_src2_is_imm | !busy(a_r2)).
- In NORMAL, when the head is not SERIAL:
  - issue A iff ok_a.
  - also issue B iff all of: b_valid; b_class != SERIAL; a_is_br = 0; not (a_class = MEM and b_class = MEM); b sources not busy; b_r1/b_r2 (r2 only if !b_src2_is_imm) != a_dest when a_dest != 0; b_dest != a_dest.
  - o_size = 2, 1 or 0 accordingly. B is never issued without A.
- Scoreboard set: each issued LONG or MEM instruction with dest != 0 sets its bit at the next edge.
- Scoreboard clear: each wb_valid[i] clears wb_dest[i].
- Set and clear of the same bit in the same cycle: set wins.
- Clearing r0 or an already-clear bit has no effect.
- State machine (SERIAL head):
  - NORMAL: if a_valid & a_class=SERIAL, o_size=0 and go to DRAIN.
  - DRAIN: o_size=0. Go to ISSUE when pipe_empty & sb_empty.
  - ISSUE: o_size=1 if exe_ready, then go to WAIT; otherwise stay in ISSUE.
  - WAIT: o_size=0. Go to NORMAL when pipe_empty. A serialized instruction is never paired.
- A SERIAL instruction in slot B only blocks pairing. It is handled once it reaches slot A.
- a_valid dropping while in DRAIN (not a flush): return to NORMAL next cycle.
- serial_busy = (state != NORMAL).

Optional Feature:
- Macro: ISSUE_PERF_EN.
- When defined, four 32-bit counters are added and exposed as outputs perf_dual, perf_single, perf_stall_dep, perf_stall_serial, all reset to 0.
  - perf_dual: cycles with o_size=2.
  - perf_single: cycles with o_size=1.
  - perf_stall_dep: cycles with a_valid & exe_ready & o_size=0 due to a scoreboard hit.
  - perf_stall_serial: cycles in DRAIN or WAIT.
- Counters wrap at 2^32 and are not cleared by flush.
- When not defined, the counters and their ports are absent and behaviour is otherwise identical.

Test Plan:
- Independent pair: A=ALU r1=1 dest=3, B=ALU r1=2 dest=4, exe_ready=1 -> o_size=2.
- RAW pair: A dest=5, B r1=5 -> o_size=1, next cycle B is head and issues.
- Load then use: A=MEM dest=7 issues; next head r1=7 -> o_size=0 until wb_valid[0]=1 with wb_dest=7, then o_size=1 in the following cycle.
- Serial: A=SERIAL, pipe_empty=0 for 3 cycles -> DRAIN with o_size=0; pipe_empty=1 -> ISSUE with o_size=1 -> WAIT until pipe_empty -> NORMAL.
- Same-cycle set/clear: issue LONG dest=9 while wb clears 9 -> bit 9 remains set.
- Assert reset asynchronously mid-DRAIN with scoreboard nonzero -> o_size=0, serial_busy=0 and sb_empty=1 immediately, without waiting for a clock edge.
